demod_integrate_dump: RTL and testbench

- Downstream stage of the demodulator VCO (cos/sin source).
- Multiplies each received passband sample by the VCO cos and sin outputs.
- Integrates each product over one symbol period, then dumps the I/Q sums.
- Slices the sums into a 4-bit Gray-coded 16QAM symbol for the bit-unpacking stage that follows.

---
 rtl/demod_pkg.sv | 22 ++
 rtl/demod_slicer.sv | 40 ++++
 rtl/demod_integrate_dump.sv | 182 ++++++++++++++++++
 tb/tb_demod_integrate_dump.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/demod_pkg.sv
// ----------------------------------------------------------------------------
// demod_pkg : shared defaults, FSM state type and Gray slicer table
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package demod_pkg;

  localparam int c_sample_w_def = 8;
  localparam int c_acc_w_def    = 19;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Indexed by amplitude level, most negative level first.
  localparam logic [1:0] c_gray_lut [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

endpackage

`default_nettype wire

// File: rtl/demod_slicer.sv
// ----------------------------------------------------------------------------
// demod_slicer : maps one signed integrated axis value to a 2-bit Gray code
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module demod_slicer
  import demod_pkg::*;
#(
  parameter int ACC_W  = c_acc_w_def,
  parameter int THRESH = 32768
) (
  input  logic [ACC_W-1:0] x_i,
  output logic [1:0]       code_o
);

  localparam logic signed [ACC_W-1:0] c_pos = ACC_W'(THRESH);
  localparam logic signed [ACC_W-1:0] c_neg = ACC_W'(-THRESH);

  logic signed [ACC_W-1:0] w_x;
  logic [1:0]              w_level;

  assign w_x = x_i;

  always_comb begin
    w_level = 2'd3;
    if (w_x < c_neg) begin
      w_level = 2'd0;
    end else if (w_x[ACC_W-1]) begin
      w_level = 2'd1;
    end else if (w_x < c_pos) begin
      w_level = 2'd2;
    end
  end

  assign code_o = c_gray_lut[w_level];

endmodule

`default_nettype wire

// File: rtl/demod_integrate_dump.sv
// ----------------------------------------------------------------------------
// demod_integrate_dump : I/Q mix, integrate-and-dump per symbol, 16QAM slice
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module demod_integrate_dump
  import demod_pkg::*;
#(
  parameter int SAMPLE_W = c_sample_w_def,
  parameter int SYM_LEN  = 8,
  parameter int ACC_W    = c_acc_w_def,
  parameter int THRESH   = 32768
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [SAMPLE_W-1:0] cos,
  input  logic [SAMPLE_W-1:0] sin,
  input  logic                sym_start,
  output logic                out_valid,
  output logic [ACC_W-1:0]    i_sum,
  output logic [ACC_W-1:0]    q_sum,
  output logic [3:0]          symbol
);

  localparam int                 c_cnt_w    = $clog2(SYM_LEN);
  localparam int                 c_prod_w   = 2 * SAMPLE_W;
  localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(SYM_LEN - 1);

  state_t             state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [c_cnt_w-1:0] w_idx;
  logic               w_accept;

  // Capture stage: the edge that accepts a sample also fixes its index.
  logic                       s0_valid_q, s0_first_q, s0_last_q;
  logic signed [SAMPLE_W-1:0] s0_sample_q, s0_cos_q, s0_sin_q;

  logic                       s1_valid_q, s1_first_q, s1_last_q;
  logic signed [c_prod_w-1:0] p_i_q, p_q_q;

  logic [ACC_W-1:0] acc_i_q, acc_q_q;
  logic [ACC_W-1:0] i_sum_q, q_sum_q;
  logic             s2_dump_q;

  logic       out_valid_q;
  logic [3:0] symbol_q;

  logic [ACC_W-1:0] w_pi_ext, w_pq_ext, w_sum_i, w_sum_q;
  logic [1:0]       w_code_i, w_code_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    w_accept = 1'b0;
    w_idx    = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid && sym_start) begin
          state_d  = RUN;
          w_accept = 1'b1;
          w_idx    = '0;
          cnt_d    = c_cnt_w'(1);
        end
      end
      RUN: begin
        if (in_valid) begin
          w_accept = 1'b1;
          // A start at a nonzero index restarts the symbol; the partial sum is
          // overwritten by the fresh index-0 load and never reaches a dump.
          if (sym_start) begin
            w_idx = '0;
          end
          cnt_d = w_idx + c_cnt_w'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign w_pi_ext = {{(ACC_W - c_prod_w){p_i_q[c_prod_w-1]}}, p_i_q};
  assign w_pq_ext = {{(ACC_W - c_prod_w){p_q_q[c_prod_w-1]}}, p_q_q};
  assign w_sum_i  = acc_i_q + w_pi_ext;
  assign w_sum_q  = acc_q_q + w_pq_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_q  <= 1'b0;
      s0_first_q  <= 1'b0;
      s0_last_q   <= 1'b0;
      s0_sample_q <= '0;
      s0_cos_q    <= '0;
      s0_sin_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      p_i_q       <= '0;
      p_q_q       <= '0;
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      i_sum_q     <= '0;
      q_sum_q     <= '0;
      s2_dump_q   <= 1'b0;
      out_valid_q <= 1'b0;
      symbol_q    <= '0;
    end else begin
      s0_valid_q <= w_accept;
      if (w_accept) begin
        s0_first_q  <= (w_idx == '0);
        s0_last_q   <= (w_idx == c_last_idx);
        s0_sample_q <= sample;
        s0_cos_q    <= cos;
        s0_sin_q    <= sin;
      end

      s1_valid_q <= s0_valid_q;
      if (s0_valid_q) begin
        s1_first_q <= s0_first_q;
        s1_last_q  <= s0_last_q;
        p_i_q      <= s0_sample_q * s0_cos_q;
        p_q_q      <= s0_sample_q * s0_sin_q;
      end

      s2_dump_q <= s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        if (s1_last_q) begin
          i_sum_q <= w_sum_i;
          q_sum_q <= w_sum_q;
          acc_i_q <= '0;
          acc_q_q <= '0;
        end else if (s1_first_q) begin
          acc_i_q <= w_pi_ext;
          acc_q_q <= w_pq_ext;
        end else begin
          acc_i_q <= w_sum_i;
          acc_q_q <= w_sum_q;
        end
      end

      out_valid_q <= s2_dump_q;
      if (s2_dump_q) begin
        symbol_q <= {w_code_i, w_code_q};
      end
    end
  end

  demod_slicer #(
    .ACC_W  (ACC_W),
    .THRESH (THRESH)
  ) u_slice_i (
    .x_i    (i_sum_q),
    .code_o (w_code_i)
  );

  demod_slicer #(
    .ACC_W  (ACC_W),
    .THRESH (THRESH)
  ) u_slice_q (
    .x_i    (q_sum_q),
    .code_o (w_code_q)
  );

  assign out_valid = out_valid_q;
  assign i_sum     = i_sum_q;
  assign q_sum     = q_sum_q;
  assign symbol    = symbol_q;

endmodule

`default_nettype wire

// File: tb/tb_demod_integrate_dump.sv
// ----------------------------------------------------------------------------
// tb_demod_integrate_dump : directed vectors with hand-computed dump values
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_demod_integrate_dump;

  localparam int SAMPLE_W = 8;
  localparam int ACC_W    = 19;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic [SAMPLE_W-1:0] sample;
  logic [SAMPLE_W-1:0] cos;
  logic [SAMPLE_W-1:0] sin;
  logic                sym_start;
  logic                out_valid;
  logic [ACC_W-1:0]    i_sum;
  logic [ACC_W-1:0]    q_sum;
  logic [3:0]          symbol;

  demod_integrate_dump #(
    .SAMPLE_W (SAMPLE_W),
    .SYM_LEN  (8),
    .ACC_W    (ACC_W),
    .THRESH   (32768)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .sample    (sample),
    .cos       (cos),
    .sin       (sin),
    .sym_start (sym_start),
    .out_valid (out_valid),
    .i_sum     (i_sum),
    .q_sum     (q_sum),
    .symbol    (symbol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int pulses   = 0;
  int last_pulse_cyc = 0;
  int prev_pulse_cyc = 0;
  int last_accept    = 0;
  int base;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      pulses         <= pulses + 1;
      prev_pulse_cyc <= last_pulse_cyc;
      last_pulse_cyc <= cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk_value(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic int sx(input logic [ACC_W-1:0] v);
    return int'($signed(v));
  endfunction

  // Inputs change on the falling edge; the following rising edge samples them.
  task automatic drive(input logic v, input logic st, input int s, input int c, input int sn);
    @(negedge clk);
    in_valid  = v;
    sym_start = st;
    sample    = SAMPLE_W'(s);
    cos       = SAMPLE_W'(c);
    sin       = SAMPLE_W'(sn);
    if (v) last_accept = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 0, 0, 0);
    #1;
  endtask

  task automatic send_sym(input int s, input int c, input int sn, input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      drive(1'b1, k == 0, s, c, sn);
      if (gap > 0) repeat (gap) drive(1'b0, 1'b0, 0, 0, 0);
    end
  endtask

  task automatic expect_dump(input string tag, input int n_new, input int ei, input int eq,
                             input int esym);
    chk_value({tag, "_pulses"}, pulses - base, n_new);
    chk_value({tag, "_i_sum"}, sx(i_sum), ei);
    chk_value({tag, "_q_sum"}, sx(q_sum), eq);
    chk_value({tag, "_symbol"}, int'(symbol), esym);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    sym_start = 1'b0;
    sample = '0;
    cos = '0;
    sin = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(1);
    chk_value("rst_out_valid", int'(out_valid), 0);
    chk_value("rst_i_sum", sx(i_sum), 0);
    chk_value("rst_q_sum", sx(q_sum), 0);
    chk_value("rst_symbol", int'(symbol), 0);

    base = pulses;
    send_sym(64, 127, 0, 8, 0);
    idle(6);
    expect_dump("symA", 1, 65024, 0, 4'b1011);
    chk_value("symA_latency", last_pulse_cyc - last_accept, 3);

    base = pulses;
    send_sym(-128, -128, -128, 8, 0);
    idle(6);
    expect_dump("symB", 1, 131072, 131072, 4'b1010);

    base = pulses;
    send_sym(10, 91, -91, 8, 0);
    idle(6);
    expect_dump("symC", 1, 7280, -7280, 4'b1101);

    base = pulses;
    send_sym(64, 127, 0, 8, 0);
    send_sym(-64, 127, 0, 8, 0);
    idle(6);
    expect_dump("b2b", 2, -65024, 0, 4'b0011);
    chk_value("b2b_spacing", last_pulse_cyc - prev_pulse_cyc, 8);

    base = pulses;
    send_sym(64, 127, 0, 8, 1);
    send_sym(10, 91, -91, 8, 1);
    idle(6);
    expect_dump("gap", 2, 7280, -7280, 4'b1101);
    chk_value("gap_spacing", last_pulse_cyc - prev_pulse_cyc, 16);

    base = pulses;
    send_sym(100, 100, 100, 5, 0);
    send_sym(-128, -128, -128, 8, 0);
    idle(6);
    expect_dump("resync", 1, 131072, 131072, 4'b1010);
    chk_value("resync_latency", last_pulse_cyc - last_accept, 3);

    base = pulses;
    send_sym(64, 127, 0, 4, 0);
    drive(1'b1, 1'b0, 64, 127, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    idle(8);
    expect_dump("rst_mid", 0, 0, 0, 0);

    base = pulses;
    send_sym(64, 127, 64, 8, 0);
    idle(2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(6);
    expect_dump("rst_dump", 0, 0, 0, 0);

    base = pulses;
    for (int k = 0; k < 8; k++) drive(1'b1, 1'b0, 64, 127, 0);
    idle(8);
    chk_value("idle_ignore_pulses", pulses - base, 0);

    base = pulses;
    send_sym(50, 100, 100, 8, 0);
    idle(6);
    expect_dump("final", 1, 40000, 40000, 4'b1010);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
